// File: rtl/ram_pkg.sv
// ============================================================================
// Module      : ram_pkg
// Description : Shared types, constants and the byte-merge helper used by
//               the ram_pipe write path and write-first bypass.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_pkg;

  typedef enum logic {RAM_CLEAR, RAM_READY} ram_state_e;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Widest word the helper handles; callers widen their operands to this
  // size and keep only the low D_WIDTH bits of the result.
  localparam int MAX_DW = 256;
  localparam int MAX_BE = MAX_DW / 8;

  // Replace the bytes of old_w selected by be with the matching bytes of new_w.
  function automatic logic [MAX_DW-1:0] byte_merge(
    input logic [MAX_DW-1:0] old_w,
    input logic [MAX_DW-1:0] new_w,
    input logic [MAX_BE-1:0] be
  );
    logic [MAX_DW-1:0] res;
    res = old_w;
    for (int i = 0; i < MAX_BE; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_rd_pipe.sv
// ============================================================================
// Module      : ram_rd_pipe
// Description : RD_LATENCY-deep read-return shift register carrying
//               {valid, data, err}. Data/err stages load only behind a valid
//               bit so the output word holds between reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_rd_pipe #(
  parameter int D_WIDTH    = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [D_WIDTH-1:0] in_data,
  input  logic               in_err,
  output logic               out_valid,
  output logic [D_WIDTH-1:0] out_data
);

  logic               v [0:RD_LATENCY-1];
  logic [D_WIDTH-1:0] d [0:RD_LATENCY-1];
  logic               e [0:RD_LATENCY-1];

  // Shift the read return forward one stage per cycle; reset flushes all stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        v[i] <= 1'b0;
        d[i] <= '0;
        e[i] <= 1'b0;
      end
    end else begin
      v[0] <= in_valid;
      if (in_valid) begin
        d[0] <= in_data;
        e[0] <= in_err;
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        v[i] <= v[i-1];
        if (v[i-1]) begin
          d[i] <= d[i-1];
          e[i] <= e[i-1];
        end
      end
    end
  end

  // Out-of-range reads return zero regardless of what the stage captured.
  assign out_valid = v[RD_LATENCY-1];
  assign out_data  = e[RD_LATENCY-1] ? '0 : d[RD_LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/ram_pipe.sv
// ============================================================================
// Module      : ram_pipe
// Description : Single-clock simple dual-port RAM with byte enables,
//               configurable read latency, read-during-write policy,
//               address range check and post-reset zero-fill engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_pipe
  import ram_pkg::*;
#(
  parameter int D_WIDTH        = 32,
  parameter int A_WIDTH        = 5,
  parameter int DEPTH          = 2**A_WIDTH,
  parameter int RD_LATENCY     = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 write_en,
  input  logic [A_WIDTH-1:0]   write_addr,
  input  logic [D_WIDTH-1:0]   write_data,
  input  logic [D_WIDTH/8-1:0] write_be,
  input  logic                 read_en,
  input  logic [A_WIDTH-1:0]   read_addr,
  output logic [D_WIDTH-1:0]   read_data,
  output logic                 read_valid,
  output logic                 init_busy,
  output logic                 addr_err
);

  logic [D_WIDTH-1:0] mem [0:DEPTH-1];

  ram_state_e         state;
  ram_state_e         next_state;
  logic [A_WIDTH-1:0] clr_cnt;
  logic               clr_last;
  logic               ready;
  logic               wr_ok;
  logic               rd_ok;
  logic               wr_fire;
  logic               rd_fire;
  logic               rdw_hit;
  logic [D_WIDTH-1:0] wr_old;
  logic [D_WIDTH-1:0] wr_word;
  logic [D_WIDTH-1:0] rd_word;
  logic [D_WIDTH-1:0] rd_pipe_in;
  logic [MAX_DW-1:0]  wr_merge_full;
  logic [MAX_DW-1:0]  byp_merge_full;

  // State register: CLEAR after reset when zero-fill is enabled, else READY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= (CLEAR_ON_RESET != 0) ? RAM_CLEAR : RAM_READY;
    else        state <= next_state;
  end

  // Next state: leave CLEAR once the last word has been zeroed; READY is terminal.
  always_comb begin
    next_state = state;
    ready      = (state == RAM_READY);
    init_busy  = (state == RAM_CLEAR);
    clr_last   = (32'(clr_cnt) == DEPTH - 1);
    if (state == RAM_CLEAR && clr_last) next_state = RAM_READY;
  end

  // Clear counter walks the array once per reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  clr_cnt <= '0;
    else if (state == RAM_CLEAR) clr_cnt <= clr_cnt + A_WIDTH'(1);
  end

  // Request decode, byte merge and write-first bypass; out-of-range words read as zero.
  always_comb begin
    wr_ok          = (32'(write_addr) < DEPTH);
    rd_ok          = (32'(read_addr) < DEPTH);
    wr_fire        = ready && write_en && wr_ok;
    rd_fire        = ready && read_en;
    wr_old         = wr_ok ? mem[write_addr] : '0;
    rd_word        = rd_ok ? mem[read_addr] : '0;
    wr_merge_full  = byte_merge(MAX_DW'(wr_old), MAX_DW'(write_data), MAX_BE'(write_be));
    wr_word        = wr_merge_full[D_WIDTH-1:0];
    byp_merge_full = byte_merge(MAX_DW'(rd_word), MAX_DW'(write_data), MAX_BE'(write_be));
    rdw_hit        = (RDW_MODE == RDW_WRITE_FIRST) && wr_fire && rd_ok &&
                     (write_addr == read_addr);
    rd_pipe_in     = rdw_hit ? byp_merge_full[D_WIDTH-1:0] : rd_word;
  end

  // Array write port: zero-fill during CLEAR, byte-merged user writes in READY.
  always_ff @(posedge clk) begin
    if (state == RAM_CLEAR) mem[clr_cnt]    <= '0;
    else if (wr_fire)       mem[write_addr] <= wr_word;
  end

  // One pulse per cycle containing any accepted out-of-range request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_err <= 1'b0;
    else        addr_err <= ready && ((write_en && !wr_ok) || (read_en && !rd_ok));
  end

  ram_rd_pipe #(
    .D_WIDTH    (D_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_fire),
    .in_data   (rd_pipe_in),
    .in_err    (!rd_ok),
    .out_valid (read_valid),
    .out_data  (read_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_ram_pipe.sv
// ============================================================================
// Module      : tb_ram_pipe
// Description : Directed self-checking bench. Instance A: DEPTH 32, latency 1,
//               read-first. Instance B: DEPTH 20, latency 2, write-first.
//               Both share one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_pipe;

  logic        clk;
  logic        rst_n;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [3:0]  write_be;
  logic        read_en;
  logic [4:0]  read_addr;

  logic [31:0] rd_a, rd_b;
  logic        rv_a, rv_b, ib_a, ib_b, ae_a, ae_b;

  int checks = 0;
  int errors = 0;

  ram_pipe #(
    .D_WIDTH(32), .A_WIDTH(5), .DEPTH(32), .RD_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)
  ) u_a (
    .clk(clk), .rst_n(rst_n),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data), .write_be(write_be),
    .read_en(read_en), .read_addr(read_addr),
    .read_data(rd_a), .read_valid(rv_a), .init_busy(ib_a), .addr_err(ae_a)
  );

  ram_pipe #(
    .D_WIDTH(32), .A_WIDTH(5), .DEPTH(20), .RD_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)
  ) u_b (
    .clk(clk), .rst_n(rst_n),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data), .write_be(write_be),
    .read_en(read_en), .read_addr(read_addr),
    .read_data(rd_b), .read_valid(rv_b), .init_busy(ib_b), .addr_err(ae_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    write_en = 1'b1; write_addr = a; write_data = d; write_be = be;
    tick();
    write_en = 1'b0;
  endtask

  // Read on both instances: A answers after one edge, B after two; A must hold.
  task automatic rd_check(input string tag, input logic [4:0] a,
                          input logic [31:0] exp_a, input logic [31:0] exp_b);
    read_en = 1'b1; read_addr = a;
    tick();
    read_en = 1'b0;
    chk({tag, "_rv_a"}, rv_a, 1);
    chk({tag, "_rd_a"}, rd_a, exp_a);
    chk({tag, "_rv_b_early"}, rv_b, 0);
    tick();
    chk({tag, "_rv_a_off"}, rv_a, 0);
    chk({tag, "_rd_a_hold"}, rd_a, exp_a);
    chk({tag, "_rv_b"}, rv_b, 1);
    chk({tag, "_rd_b"}, rd_b, exp_b);
  endtask

  // Count edges until init_busy drops; requests left on are withdrawn after 3 edges.
  task automatic clear_count(input string tag);
    int na, nb;
    na = -1; nb = -1;
    for (int n = 1; n <= 64; n++) begin
      tick();
      if (n == 3) begin write_en = 1'b0; read_en = 1'b0; end
      if (n <= 40) begin
        chk({tag, "_rv_a"}, rv_a, 0);
        chk({tag, "_rv_b"}, rv_b, 0);
        chk({tag, "_ae_a"}, ae_a, 0);
        chk({tag, "_ae_b"}, ae_b, 0);
      end
      if (na < 0 && !ib_a) na = n;
      if (nb < 0 && !ib_b) nb = n;
    end
    chk({tag, "_len_a"}, na, 32);
    chk({tag, "_len_b"}, nb, 20);
  endtask

  initial begin
    rst_n = 1'b0; write_en = 1'b0; write_addr = '0; write_data = '0; write_be = '0;
    read_en = 1'b0; read_addr = '0;
    #16;
    chk("rst_rv_a", rv_a, 0);
    chk("rst_rv_b", rv_b, 0);
    chk("rst_rd_a", rd_a, 0);
    chk("rst_ae_a", ae_a, 0);
    chk("rst_ib_a", ib_a, 1);
    chk("rst_ib_b", ib_b, 1);
    rst_n = 1'b1;

    // Requests during CLEAR must be ignored.
    write_en = 1'b1; write_addr = 5'h10; write_data = 32'h12345678; write_be = 4'hF;
    read_en = 1'b1; read_addr = 5'h10;
    clear_count("clr1");
    rd_check("clr_ignored", 5'h10, 32'h0, 32'h0);

    // Byte-enable writes.
    wr(5'h10, 32'hFFFFFFFF, 4'hF);
    wr(5'h10, 32'hAABBCCDD, 4'h5);
    rd_check("byte_wr", 5'h10, 32'hFFBBFFDD, 32'hFFBBFFDD);

    // Read-during-write at 0x03.
    wr(5'h03, 32'h11111111, 4'hF);
    write_en = 1'b1; write_addr = 5'h03; write_data = 32'h22222222; write_be = 4'h3;
    read_en = 1'b1; read_addr = 5'h03;
    tick();
    write_en = 1'b0; read_en = 1'b0;
    chk("rdw_rv_a", rv_a, 1);
    chk("rdw_rd_a_old", rd_a, 32'h11111111);
    tick();
    chk("rdw_rv_b", rv_b, 1);
    chk("rdw_rd_b_new", rd_b, 32'h11112222);
    rd_check("rdw_after", 5'h03, 32'h11112222, 32'h11112222);

    // Streaming reads over 0..7 holding addr*3.
    for (int i = 0; i < 8; i++) wr(5'(i), 32'(i * 3), 4'hF);
    for (int i = 0; i < 8; i++) begin
      read_en = 1'b1; read_addr = 5'(i);
      tick();
      chk("stream_rv_a", rv_a, 1);
      chk("stream_rd_a", rd_a, 32'(i * 3));
      if (i == 0) chk("stream_rv_b0", rv_b, 0);
      else begin
        chk("stream_rv_b", rv_b, 1);
        chk("stream_rd_b", rd_b, 32'((i - 1) * 3));
      end
    end
    read_en = 1'b0;
    tick();
    chk("stream_end_rv_a", rv_a, 0);
    chk("stream_end_rv_b", rv_b, 1);
    chk("stream_end_rd_b", rd_b, 32'd21);
    tick();
    chk("stream_done_rv_b", rv_b, 0);

    // Range check: 0x18 is out of range for B only.
    wr(5'h18, 32'hDEADBEEF, 4'hF);
    chk("oor_wr_ae_b", ae_b, 1);
    chk("oor_wr_ae_a", ae_a, 0);
    tick();
    chk("oor_wr_ae_b_once", ae_b, 0);
    rd_check("oor_alias4", 5'h04, 32'd12, 32'd12);
    rd_check("oor_alias8", 5'h08, 32'd0, 32'd0);
    read_en = 1'b1; read_addr = 5'h18;
    tick();
    read_en = 1'b0;
    chk("oor_rd_ae_b", ae_b, 1);
    chk("oor_rd_rv_a", rv_a, 1);
    chk("oor_rd_rd_a", rd_a, 32'hDEADBEEF);
    tick();
    chk("oor_rd_ae_b_once", ae_b, 0);
    chk("oor_rd_rv_b", rv_b, 1);
    chk("oor_rd_rd_b", rd_b, 32'h0);
    write_en = 1'b1; write_addr = 5'h19; write_data = 32'h55555555; write_be = 4'hF;
    read_en = 1'b1; read_addr = 5'h18;
    tick();
    write_en = 1'b0; read_en = 1'b0;
    chk("oor_both_ae_b", ae_b, 1);
    chk("oor_both_rd_a", rd_a, 32'hDEADBEEF);
    tick();
    chk("oor_both_ae_b_once", ae_b, 0);
    tick();

    // Mid-operation reset with an in-flight read and a pending error pulse.
    read_en = 1'b1; read_addr = 5'h18;
    tick();
    read_en = 1'b0;
    chk("mid_pre_ae_b", ae_b, 1);
    chk("mid_pre_rv_a", rv_a, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rv_a", rv_a, 0);
    chk("mid_rd_a", rd_a, 0);
    chk("mid_ae_b", ae_b, 0);
    chk("mid_ib_a", ib_a, 1);
    tick();
    chk("mid_rv_b_flushed", rv_b, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_clr10_ib_a", ib_a, 1);
    chk("mid_clr10_ib_b", ib_b, 1);
    #2 rst_n = 1'b0;
    tick();
    chk("mid_clr_rst_ib_a", ib_a, 1);
    rst_n = 1'b1;
    clear_count("clr2");
    rd_check("reclr_10", 5'h10, 32'h0, 32'h0);
    rd_check("reclr_04", 5'h04, 32'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
